packet_input_buffer: RTL

Upstream stage of the packet fetch block: an AXI-Stream slave that captures one frame of RANC input packets per tick into a local buffer, then holds it for the fetch stage. It publishes `num_packets` and `data_valid` to the fetch stage and serves `packet_out` at the `addr` the fetch stage drives. It releases the frame on `read_done` or `tick`, then reopens for the next frame.

---
 rtl/packet_input_buffer_pkg.sv | 29 ++
 rtl/packet_input_buffer_sdp_ram.sv | 42 ++++
 rtl/packet_input_buffer.sv | 137 +++++++++++++
 3 files changed

// File: rtl/packet_input_buffer_pkg.sv
// Shared definitions for the packet input buffer: buffer state encoding and
// the address-width helper used to size pointers and counters.

package packet_input_buffer_pkg;

    // Frame capture states. FILL accepts words, DRAIN swallows the tail of an
    // oversized frame, HOLD presents a complete frame to the fetch stage.
    typedef enum logic [1:0] {
        FILL  = 2'b00,
        DRAIN = 2'b01,
        HOLD  = 2'b10
    } buf_state_e;

    // Number of bits needed to represent 'value' (clogb2(31) = 5).
    function automatic int clogb2(input int value);
        int remaining;
        int result;
        remaining = value;
        result    = 0;
        for (int i = 0; i < 32; i++) begin
            if (remaining > 0) begin
                result    = result + 1;
                remaining = remaining >> 1;
            end
        end
        return result;
    endfunction

endpackage

// File: rtl/packet_input_buffer_sdp_ram.sv
// Simple dual-port packet storage: port A writes, port B reads through an
// output register. Storage itself is never cleared; only the read register
// has a reset value so the published packet word starts at zero.

module sdp_ram
    import packet_input_buffer_pkg::*;
#(
    parameter int DEPTH = 32,
    parameter int WIDTH = 32,
    localparam int ADDR_W = clogb2(DEPTH - 1)
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              wea_i,
    input  logic [ADDR_W-1:0] addra_i,
    input  logic [WIDTH-1:0]  dina_i,
    input  logic [ADDR_W-1:0] addrb_i,
    output logic [WIDTH-1:0]  doutb_o
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [WIDTH-1:0] doutb_q;

    // Port A write: the word lands in storage on the edge of its handshake.
    always_ff @(posedge clk_i) begin
        if (wea_i) begin
            mem[addra_i] <= dina_i;
        end
    end

    // Port B registered read: one cycle from address to data.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            doutb_q <= '0;
        end else begin
            doutb_q <= mem[addrb_i];
        end
    end

    assign doutb_o = doutb_q;

endmodule

// File: rtl/packet_input_buffer.sv
// AXI-Stream slave that captures one frame of RANC packets per tick, holds it
// for the fetch stage, and releases it on read_done or tick. Words beyond the
// buffer capacity are accepted and dropped, and flagged with a sticky overflow.

module packet_input_buffer
    import packet_input_buffer_pkg::*;
#(
    parameter int NUMBER_OF_INPUT_WORDS = 32,
    parameter int DATA_WIDTH = 32,
    localparam int bit_num = clogb2(NUMBER_OF_INPUT_WORDS - 1),
    localparam int CAP = NUMBER_OF_INPUT_WORDS - 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] s_axis_tdata,
    input  logic                  s_axis_tvalid,
    input  logic                  s_axis_tlast,
    output logic                  s_axis_tready,
    input  logic                  tick,
    input  logic                  read_done,
    input  logic [bit_num-1:0]    addr,
    output logic [DATA_WIDTH-1:0] packet_out,
    output logic [bit_num-1:0]    num_packets,
    output logic                  data_valid,
    output logic                  overflow
);

    // The write pointer carries one extra bit so comparing it with CAP can
    // never wrap, even though CAP itself fits in bit_num bits.
    localparam logic [bit_num:0]   CAP_PTR = (bit_num + 1)'(CAP);
    localparam logic [bit_num:0]   ONE_PTR = (bit_num + 1)'(1);
    localparam logic [bit_num-1:0] CAP_CNT = bit_num'(CAP);
    localparam logic [bit_num-1:0] ONE_CNT = bit_num'(1);

    buf_state_e           state_q, state_d;
    logic [bit_num:0]     wr_ptr_q, wr_ptr_d;
    logic [bit_num-1:0]   num_packets_q, num_packets_d;
    logic                 data_valid_q, data_valid_d;
    logic                 overflow_q, overflow_d;

    logic                 handshake;
    logic                 room_left;
    logic                 mem_we;

    // Ready depends on the registered state alone so upstream never sees a
    // combinational path from its own valid back to ready.
    assign s_axis_tready = (state_q != HOLD);
    assign handshake     = s_axis_tvalid & s_axis_tready;
    assign room_left     = (wr_ptr_q < CAP_PTR);
    assign mem_we        = (state_q == FILL) & handshake & room_left;

    // Next-state decode for the capture FSM, pointer and frame flags.
    always_comb begin
        state_d       = state_q;
        wr_ptr_d      = wr_ptr_q;
        num_packets_d = num_packets_q;
        data_valid_d  = data_valid_q;
        overflow_d    = overflow_q;

        unique case (state_q)
            FILL: begin
                if (handshake) begin
                    if (room_left) begin
                        wr_ptr_d = wr_ptr_q + ONE_PTR;
                        if (s_axis_tlast) begin
                            num_packets_d = wr_ptr_q[bit_num-1:0] + ONE_CNT;
                            data_valid_d  = 1'b1;
                            state_d       = HOLD;
                        end
                    end else begin
                        overflow_d = 1'b1;
                        if (s_axis_tlast) begin
                            num_packets_d = CAP_CNT;
                            data_valid_d  = 1'b1;
                            state_d       = HOLD;
                        end else begin
                            state_d = DRAIN;
                        end
                    end
                end
            end
            DRAIN: begin
                if (handshake && s_axis_tlast) begin
                    num_packets_d = CAP_CNT;
                    data_valid_d  = 1'b1;
                    state_d       = HOLD;
                end
            end
            HOLD: begin
                if (read_done || tick) begin
                    wr_ptr_d      = '0;
                    num_packets_d = '0;
                    data_valid_d  = 1'b0;
                    state_d       = FILL;
                end
            end
            default: begin
                state_d = FILL;
            end
        endcase
    end

    // Register the FSM state together with its registered outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q       <= FILL;
            wr_ptr_q      <= '0;
            num_packets_q <= '0;
            data_valid_q  <= 1'b0;
            overflow_q    <= 1'b0;
        end else begin
            state_q       <= state_d;
            wr_ptr_q      <= wr_ptr_d;
            num_packets_q <= num_packets_d;
            data_valid_q  <= data_valid_d;
            overflow_q    <= overflow_d;
        end
    end

    sdp_ram #(
        .DEPTH(NUMBER_OF_INPUT_WORDS),
        .WIDTH(DATA_WIDTH)
    ) u_ram (
        .clk_i  (clk),
        .rst_ni (rst),
        .wea_i  (mem_we),
        .addra_i(wr_ptr_q[bit_num-1:0]),
        .dina_i (s_axis_tdata),
        .addrb_i(addr),
        .doutb_o(packet_out)
    );

    assign num_packets = num_packets_q;
    assign data_valid  = data_valid_q;
    assign overflow    = overflow_q;

endmodule
